lav_serial_rx: RTL and testbench

LAV_SERIAL_RX -- requirements
Module: lav_serial_rx

---
 rtl/lav_serial_rx.sv | 163 ++++++++++++++++
 tb/tb_lav_serial_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lav_serial_rx.sv
// Oversampling serial receiver: 8 data bits, LSB first, optional even parity, one stop bit.
// Delivers each byte through a valid/ready holding register with sticky overflow.
module lav_serial_rx #(
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 1
) (
  input  logic       upf_clk,
  input  logic       lav_reset,
  input  logic       lav_rx_in,
  input  logic       lav_rx_en,
  input  logic       lav_rd_ready,
  output logic [7:0] lav_rx_data,
  output logic       lav_rx_valid,
  output logic       lav_par_err,
  output logic       lav_frm_err,
  output logic       lav_ovf,
  output logic       lav_busy
);

  localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_par;
  logic            r_frm;
  logic            r_dlv;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_par_err;
  logic            r_frm_err;
  logic            r_ovf;
  logic            w_rx_s;

  function automatic logic f_even_par(input logic [7:0] d);
    return ^d;
  endfunction

  assign w_rx_s = r_sync2;

  // Synchronizer and frame FSM; r_dlv pulses the cycle after the stop sample.
  always_ff @(posedge upf_clk or posedge lav_reset) begin
    if (lav_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_frm   <= 1'b0;
      r_dlv   <= 1'b0;
    end else begin
      r_sync1 <= lav_rx_in;
      r_sync2 <= r_sync1;
      r_dlv   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s && lav_rx_en) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == HALF_LAST) begin
            if (w_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_cnt   <= '0;
              r_bit   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == FULL_LAST) begin
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_cnt   <= '0;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (r_cnt == FULL_LAST) begin
            r_par   <= w_rx_s ^ f_even_par(r_shift);
            r_cnt   <= '0;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == FULL_LAST) begin
            r_frm   <= ~w_rx_s;
            r_dlv   <= 1'b1;
            r_cnt   <= '0;
            r_state <= w_rx_s ? S_IDLE : S_BREAK;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          if (w_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Holding register: a delivery replaces the held byte only if it is free or leaving this cycle.
  always_ff @(posedge upf_clk or posedge lav_reset) begin
    if (lav_reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (r_dlv) begin
        if (!r_valid || lav_rd_ready) begin
          r_data    <= r_shift;
          r_par_err <= r_par;
          r_frm_err <= r_frm;
          r_valid   <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_valid && lav_rd_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign lav_rx_data  = r_data;
  assign lav_rx_valid = r_valid;
  assign lav_par_err  = r_par_err;
  assign lav_frm_err  = r_frm_err;
  assign lav_ovf      = r_ovf;
  assign lav_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_lav_serial_rx.sv
// Scoreboard bench for lav_serial_rx: frames are modelled as bit sequences and expected
// bytes/flags queued at send time; a monitor pops on every handshake transfer.
module tb_lav_serial_rx;

  localparam int BC  = 4;
  localparam int PEN = 1;

  logic       clk = 1'b0;
  logic       lav_reset;
  logic       lav_rx_in;
  logic       lav_rx_en;
  logic       lav_rd_ready;
  logic [7:0] lav_rx_data;
  logic       lav_rx_valid;
  logic       lav_par_err;
  logic       lav_frm_err;
  logic       lav_ovf;
  logic       lav_busy;

  logic       rand_mode = 1'b0;
  logic       r_rand = 1'b1;
  logic       ready_fixed = 1'b1;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [9:0] exp_q[$];

  assign lav_rd_ready = rand_mode ? r_rand : ready_fixed;

  lav_serial_rx #(.BIT_CYCLES(BC), .PARITY_EN(PEN)) dut (
    .upf_clk     (clk),
    .lav_reset   (lav_reset),
    .lav_rx_in   (lav_rx_in),
    .lav_rx_en   (lav_rx_en),
    .lav_rd_ready(lav_rd_ready),
    .lav_rx_data (lav_rx_data),
    .lav_rx_valid(lav_rx_valid),
    .lav_par_err (lav_par_err),
    .lav_frm_err (lav_frm_err),
    .lav_ovf     (lav_ovf),
    .lav_busy    (lav_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      lav_rx_in = bits[i];
      tick(BC);
    end
  endtask

  // Frame on the wire: start 0, data LSB first, parity bit p, stop bit s.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit push);
    if (push) exp_q.push_back({d, p ^ (^d), ~s});
    drive_bits({s, p, d, 1'b0}, 11);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      r_rand = ($urandom_range(3) != 0);
    end
  end

  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (lav_rx_valid && lav_rd_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {22'd0, lav_rx_data, lav_par_err, lav_frm_err}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", lav_rx_data, e[9:2]);
          chk("par_err", lav_par_err, e[1]);
          chk("frm_err", lav_frm_err, e[0]);
        end
      end
    end
  end

  initial begin
    int t_b, t_v, n;
    logic [7:0] d;
    lav_reset = 1'b1;
    lav_rx_in = 1'b1;
    lav_rx_en = 1'b1;
    tick(3);
    @(negedge clk);
    chk("reset_outputs", {lav_rx_data, lav_rx_valid, lav_par_err, lav_frm_err, lav_ovf, lav_busy}, 0);
    tick(1);
    lav_reset = 1'b0;
    tick(3);

    // 0xA5, good parity and stop; latency and single-cycle valid
    t_b = 0;
    t_v = 0;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      begin
        n = 0;
        while (!lav_busy && n < 30) begin
          @(negedge clk);
          n++;
        end
        t_b = cyc;
        n = 0;
        while (!lav_rx_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        t_v = cyc;
        chk("latency", t_v - t_b, BC / 2 + 10 * BC + 1);
        @(negedge clk);
        chk("valid_one_cycle", lav_rx_valid, 1'b0);
      end
    join
    tick(4);
    wait_drain(100);

    // 0x3C with a wrong parity bit
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    tick(4);
    wait_drain(100);

    // 0x5A with low stop bit, line held low, then 0x01
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    tick(20);
    chk("busy_in_break", lav_busy, 1'b1);
    lav_rx_in = 1'b1;
    tick(4);
    chk("busy_after_break", lav_busy, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    tick(4);
    wait_drain(100);

    // one-cycle glitch is a false start
    lav_rx_in = 1'b0;
    tick(1);
    lav_rx_in = 1'b1;
    tick(4);
    chk("glitch_busy", lav_busy, 1'b0);
    tick(20);
    chk("glitch_no_valid", lav_rx_valid, 1'b0);

    // randomized frames with random consumer readiness
    rand_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'($urandom_range(1)), ($urandom_range(3) != 0), 1'b1);
      lav_rx_in = 1'b1;
      tick($urandom_range(8, 3));
    end
    rand_mode = 1'b0;
    ready_fixed = 1'b1;
    wait_drain(200);
    chk("no_ovf_yet", lav_ovf, 1'b0);

    // overflow: second frame dropped while first is held
    ready_fixed = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    tick(6);
    chk("ovf_held_data", lav_rx_data, 8'h11);
    chk("ovf_valid", lav_rx_valid, 1'b1);
    chk("ovf_set", lav_ovf, 1'b1);
    ready_fixed = 1'b1;
    tick(1);
    ready_fixed = 1'b0;
    chk("ovf_valid_cleared", lav_rx_valid, 1'b0);
    chk("ovf_sticky", lav_ovf, 1'b1);
    chk("ovf_drain", exp_q.size(), 0);
    ready_fixed = 1'b1;

    // reset during data bit 4
    drive_bits({1'b1, 1'b0, 8'hC3, 1'b0}, 5);
    lav_rx_in = 1'b0;
    tick(2);
    lav_reset = 1'b1;
    #1;
    chk("midreset_outputs", {lav_rx_data, lav_rx_valid, lav_par_err, lav_frm_err, lav_ovf, lav_busy}, 0);
    lav_rx_in = 1'b1;
    tick(3);
    lav_reset = 1'b0;
    tick(60);
    chk("midreset_no_valid", lav_rx_valid, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
    tick(4);
    wait_drain(100);
    chk("final_ovf", lav_ovf, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
